// File: rtl/time_set_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// time_set_sequencer_pkg
// Shared definitions for the time-setting sequencer: field-select codes, FSM
// state encoding, BCD range limits and the BCD seed/step helpers used by all
// three time fields.
// -----------------------------------------------------------------------------
package time_set_sequencer_pkg;

    // Field codes driven on set_sel.
    localparam logic [1:0] SEL_SEC  = 2'd0;
    localparam logic [1:0] SEL_MIN  = 2'd1;
    localparam logic [1:0] SEL_HOUR = 2'd2;
    localparam logic [1:0] SEL_NONE = 2'd3;

    // Largest legal value of each field, in packed BCD.
    localparam logic [7:0] HOUR_MAX_BCD   = 8'h23;
    localparam logic [7:0] MINSEC_MAX_BCD = 8'h59;

    typedef enum logic [2:0] {
        IDLE,
        EDIT_H,
        EDIT_M,
        EDIT_S,
        LOAD_H,
        LOAD_M,
        LOAD_S
    } state_t;

    // Sanitise a live-time digit pair before editing starts: a tens digit
    // above the field's limit or a non-decimal ones digit seeds 00.
    function automatic logic [7:0] bcd_seed(input logic [3:0] tens,
                                            input logic [3:0] ones,
                                            input logic [7:0] max_bcd);
        return (tens > max_bcd[7:4] || ones > 4'd9) ? 8'h00 : {tens, ones};
    endfunction

    // One wrapping BCD step within [00, max_bcd]. Anything at or above the
    // limit wraps to 00 on increment, so a seed such as hour 27 still recovers.
    function automatic logic [7:0] bcd_step(input logic [7:0] val,
                                            input logic [7:0] max_bcd,
                                            input logic       up);
        logic [7:0] res;
        res = val;
        if (up) begin
            if (val >= max_bcd)
                res = 8'h00;
            else if (val[3:0] >= 4'd9)
                res = {val[7:4] + 4'd1, 4'd0};
            else
                res = {val[7:4], val[3:0] + 4'd1};
        end else begin
            if (val == 8'h00)
                res = max_bcd;
            else if (val[3:0] == 4'd0)
                res = {val[7:4] - 4'd1, 4'd9};
            else
                res = {val[7:4], val[3:0] - 4'd1};
        end
        return res;
    endfunction

endpackage

// File: rtl/time_set_sequencer_btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Single push-button debouncer. The raw input must stay high for DEB_CYCLES
// consecutive CLK samples before the press is accepted; any low sample clears
// the count. raw is expected to be synchronous to CLK already.
//
// Ports:
//   CLK    system clock
//   RST    synchronous reset, active-high
//   raw    button input
//   level  debounced level, high from the accepting cycle until release
//   press  one-cycle pulse, the cycle after DEB_CYCLES consecutive highs
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int unsigned CW = $clog2(DEB_CYCLES + 1);

    logic [CW-1:0] cnt;

    // NOTE: clocked state is written with non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (RST || !raw) begin
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else if (cnt == CW'(DEB_CYCLES - 1)) begin
            // Counter saturates at DEB_CYCLES, so the pulse cannot recur
            // until a low sample re-arms it.
            cnt   <= CW'(DEB_CYCLES);
            level <= 1'b1;
            press <= 1'b1;
        end else begin
            if (cnt != CW'(DEB_CYCLES))
                cnt <= cnt + 1'b1;
            press <= 1'b0;
        end
    end

endmodule

// File: rtl/time_set_sequencer.sv
// -----------------------------------------------------------------------------
// time_set_sequencer
// Turns four raw buttons into the counter chain's time-setting controls.
// mode enters edit (seeding from the live time) and cycles hour/min/sec,
// inc/dec adjust the selected field with wrapping BCD arithmetic, ok commits
// as three single-cycle loads (hour, minute, second). The clock is frozen
// (run_en = 0) from entry into edit until the last load has been issued.
//
// Optional build macro: SET_AUTOREPEAT_EN -- a held inc/dec adds one further
// step every REPEAT_CYCLES cycles after the initial step.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   btn_mode/inc/dec/ok raw buttons
//   cur_hh..cur_sl      live time, BCD digits
//   set_high, set_low   tens/ones digit shown or loaded
//   set_sel             field: 0 sec, 1 min, 2 hour, 3 none
//   set_load            one-cycle load strobe for the field on set_sel
//   run_en              1 = clock counts, 0 = frozen
//   editing             high in every EDIT and LOAD state
// -----------------------------------------------------------------------------
module time_set_sequencer
    import time_set_sequencer_pkg::*;
#(
    parameter int unsigned DEB_CYCLES    = 4,
    parameter int unsigned REPEAT_CYCLES = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic       btn_ok,
    input  logic [3:0] cur_hh,
    input  logic [3:0] cur_hl,
    input  logic [3:0] cur_mh,
    input  logic [3:0] cur_ml,
    input  logic [3:0] cur_sh,
    input  logic [3:0] cur_sl,
    output logic [3:0] set_high,
    output logic [3:0] set_low,
    output logic [1:0] set_sel,
    output logic       set_load,
    output logic       run_en,
    output logic       editing
);

    logic press_mode, press_inc, press_dec, press_ok;
    logic lvl_mode, lvl_inc, lvl_dec, lvl_ok;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .CLK(CLK), .RST(RST), .raw(btn_mode), .level(lvl_mode), .press(press_mode));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
        .CLK(CLK), .RST(RST), .raw(btn_inc), .level(lvl_inc), .press(press_inc));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dec (
        .CLK(CLK), .RST(RST), .raw(btn_dec), .level(lvl_dec), .press(press_dec));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ok (
        .CLK(CLK), .RST(RST), .raw(btn_ok), .level(lvl_ok), .press(press_ok));

    // Only inc/dec levels matter (and only for auto-repeat).
    logic unused_lvl;
    assign unused_lvl = lvl_mode ^ lvl_ok;

    state_t     state;
    logic [7:0] eh, em, es;

    logic       is_edit;
    logic       step_req, step_up;
    logic [7:0] field_val, field_max, stepped;
    logic [7:0] seed_h, seed_m, seed_s;

    assign is_edit = (state == EDIT_H) || (state == EDIT_M) || (state == EDIT_S);

    assign seed_h = bcd_seed(cur_hh, cur_hl, HOUR_MAX_BCD);
    assign seed_m = bcd_seed(cur_mh, cur_ml, MINSEC_MAX_BCD);
    assign seed_s = bcd_seed(cur_sh, cur_sl, MINSEC_MAX_BCD);

`ifdef SET_AUTOREPEAT_EN
    localparam int unsigned RW = $clog2(REPEAT_CYCLES + 1);

    logic [RW-1:0] rpt_cnt;
    logic          any_press, hold_one, rpt_fire;

    // Exactly one of inc/dec held in an edit state, with no fresh press this
    // cycle: a fresh press (including a field change) restarts the period.
    assign any_press = press_mode | press_inc | press_dec | press_ok;
    assign hold_one  = is_edit && (lvl_inc ^ lvl_dec) && !any_press;
    assign rpt_fire  = hold_one && (rpt_cnt == RW'(REPEAT_CYCLES - 1));

    always_ff @(posedge CLK) begin
        if (RST || !hold_one || rpt_fire)
            rpt_cnt <= '0;
        else
            rpt_cnt <= rpt_cnt + 1'b1;
    end

    assign step_req = (press_inc ^ press_dec) | rpt_fire;
    assign step_up  = (press_inc ^ press_dec) ? press_inc : lvl_inc;
`else
    assign step_req = press_inc ^ press_dec;
    assign step_up  = press_inc;

    logic unused_rpt;
    assign unused_rpt = ^{lvl_inc, lvl_dec, REPEAT_CYCLES[0]};
`endif

    // Value and limit of the field currently being edited.
    always_comb begin
        // NOTE: defaults first, so every path assigns both outputs and no
        // latch is inferred.
        field_val = eh;
        field_max = HOUR_MAX_BCD;
        case (state)
            EDIT_M: begin
                field_val = em;
                field_max = MINSEC_MAX_BCD;
            end
            EDIT_S: begin
                field_val = es;
                field_max = MINSEC_MAX_BCD;
            end
            default: ;
        endcase
    end

    assign stepped = bcd_step(field_val, field_max, step_up);

    // State, edit registers and registered outputs. Each transition sets the
    // outputs that describe the state being entered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            eh       <= 8'h00;
            em       <= 8'h00;
            es       <= 8'h00;
            set_high <= 4'd0;
            set_low  <= 4'd0;
            set_sel  <= SEL_NONE;
            set_load <= 1'b0;
            run_en   <= 1'b1;
            editing  <= 1'b0;
        end else begin
            set_load <= 1'b0;
            case (state)
                IDLE: begin
                    if (press_mode) begin
                        eh                  <= seed_h;
                        em                  <= seed_m;
                        es                  <= seed_s;
                        {set_high, set_low} <= seed_h;
                        set_sel             <= SEL_HOUR;
                        run_en              <= 1'b0;
                        editing             <= 1'b1;
                        state               <= EDIT_H;
                    end
                end

                EDIT_H, EDIT_M, EDIT_S: begin
                    // ok beats mode, mode beats a step.
                    if (press_ok) begin
                        {set_high, set_low} <= eh;
                        set_sel             <= SEL_HOUR;
                        set_load            <= 1'b1;
                        state               <= LOAD_H;
                    end else if (press_mode) begin
                        case (state)
                            EDIT_H: begin
                                {set_high, set_low} <= em;
                                set_sel             <= SEL_MIN;
                                state               <= EDIT_M;
                            end
                            EDIT_M: begin
                                {set_high, set_low} <= es;
                                set_sel             <= SEL_SEC;
                                state               <= EDIT_S;
                            end
                            default: begin
                                {set_high, set_low} <= eh;
                                set_sel             <= SEL_HOUR;
                                state               <= EDIT_H;
                            end
                        endcase
                    end else if (step_req) begin
                        {set_high, set_low} <= stepped;
                        case (state)
                            EDIT_H:  eh <= stepped;
                            EDIT_M:  em <= stepped;
                            default: es <= stepped;
                        endcase
                    end
                end

                LOAD_H: begin
                    {set_high, set_low} <= em;
                    set_sel             <= SEL_MIN;
                    set_load            <= 1'b1;
                    state               <= LOAD_M;
                end

                LOAD_M: begin
                    {set_high, set_low} <= es;
                    set_sel             <= SEL_SEC;
                    set_load            <= 1'b1;
                    state               <= LOAD_S;
                end

                LOAD_S: begin
                    // Counters resume from the just-loaded time.
                    {set_high, set_low} <= 8'h00;
                    set_sel             <= SEL_NONE;
                    run_en              <= 1'b1;
                    editing             <= 1'b0;
                    state               <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_time_set_sequencer.sv
// -----------------------------------------------------------------------------
// tb_time_set_sequencer
// Directed stimulus for time_set_sequencer. A behavioural model tracks the
// edit session as phase/field/decimal values and is compared with the DUT on
// every falling edge; hand-computed literals pin key points along the way.
// -----------------------------------------------------------------------------
module tb_time_set_sequencer;

    localparam int DEB = 4;
    localparam int REP = 8;

    localparam int B_MODE = 1;
    localparam int B_INC  = 2;
    localparam int B_DEC  = 4;
    localparam int B_OK   = 8;

    logic       CLK, RST;
    logic       btn_mode, btn_inc, btn_dec, btn_ok;
    logic [3:0] cur_hh, cur_hl, cur_mh, cur_ml, cur_sh, cur_sl;
    logic [3:0] set_high, set_low;
    logic [1:0] set_sel;
    logic       set_load, run_en, editing;

    time_set_sequencer #(.DEB_CYCLES(DEB), .REPEAT_CYCLES(REP)) dut (
        .CLK(CLK), .RST(RST),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_ok(btn_ok),
        .cur_hh(cur_hh), .cur_hl(cur_hl), .cur_mh(cur_mh),
        .cur_ml(cur_ml), .cur_sh(cur_sh), .cur_sl(cur_sl),
        .set_high(set_high), .set_low(set_low), .set_sel(set_sel),
        .set_load(set_load), .run_en(run_en), .editing(editing));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [12:0] word(input logic [3:0] h, input logic [3:0] l,
                                         input logic [1:0] sel, input logic ld,
                                         input logic rn, input logic ed);
        return {h, l, sel, ld, rn, ed};
    endfunction

    logic [12:0] dut_out;
    assign dut_out = {set_high, set_low, set_sel, set_load, run_en, editing};

    // ---------------- behavioural model ----------------
    // phase 0 idle, 1 editing, 2 loading; field 2 hour, 1 min, 0 sec.
    int m_phase = 0;
    int m_field = 0;
    int m_val[3];
    int run[4];      // consecutive high samples: mode, inc, dec, ok
    bit pend[4];     // press accepted at the previous edge
    bit model_live = 1'b0;
`ifdef SET_AUTOREPEAT_EN
    int edge_n = 0;
    int anchor = 0;
`endif

    function automatic int seed(input logic [3:0] t, input logic [3:0] o, input int lim_tens);
        return (int'(t) > lim_tens || int'(o) > 9) ? 0 : int'(t) * 10 + int'(o);
    endfunction

    task automatic bump(input int f, input bit up);
        int n;
        n = (f == 2) ? 24 : 60;
        m_val[f] = up ? (m_val[f] + 1) % n : (m_val[f] + n - 1) % n;
    endtask

    task automatic model_step();
        bit raw[4];
        bit p[4];
        bit rpt;
        raw = '{btn_mode, btn_inc, btn_dec, btn_ok};
        rpt = 1'b0;
`ifdef SET_AUTOREPEAT_EN
        edge_n++;
`endif
        if (RST) begin
            m_phase = 0;
            for (int i = 0; i < 3; i++) m_val[i] = 0;
            for (int i = 0; i < 4; i++) begin run[i] = 0; pend[i] = 1'b0; end
`ifdef SET_AUTOREPEAT_EN
            anchor = edge_n;
`endif
        end else begin
            p = pend;
`ifdef SET_AUTOREPEAT_EN
            begin
                bit li, ld;
                li = run[1] >= DEB;
                ld = run[2] >= DEB;
                if (m_phase != 1 || !(li ^ ld) || p[0] || p[1] || p[2] || p[3])
                    anchor = edge_n;
                else if ((edge_n - anchor) % REP == 0)
                    rpt = 1'b1;
            end
`endif
            case (m_phase)
                0: if (p[0]) begin
                    m_val[2] = seed(cur_hh, cur_hl, 2);
                    m_val[1] = seed(cur_mh, cur_ml, 5);
                    m_val[0] = seed(cur_sh, cur_sl, 5);
                    m_phase  = 1;
                    m_field  = 2;
                end
                1: begin
                    if (p[3]) begin
                        m_phase = 2;
                        m_field = 2;
                    end else if (p[0]) m_field = (m_field == 0) ? 2 : m_field - 1;
                    else if (p[1] ^ p[2]) bump(m_field, p[1]);
                    else if (rpt) bump(m_field, run[1] >= DEB);
                end
                default: if (m_field == 0) m_phase = 0; else m_field--;
            endcase
            for (int i = 0; i < 4; i++) begin
                run[i]  = raw[i] ? run[i] + 1 : 0;
                pend[i] = (run[i] == DEB);
            end
        end
        model_live = 1'b1;
    endtask

    function automatic logic [12:0] expected();
        int v;
        if (m_phase == 0) return word(4'h0, 4'h0, 2'd3, 1'b0, 1'b1, 1'b0);
        v = m_val[m_field];
        return word(4'(v / 10), 4'(v % 10), 2'(m_field), m_phase == 2, 1'b0, 1'b1);
    endfunction

    always @(posedge CLK) model_step();

    always @(negedge CLK)
        if (model_live) check("cycle", 32'(dut_out), 32'(expected()));

    // ---------------- stimulus ----------------
    task automatic press(input int mask, input int hold);
        btn_mode = mask[0];
        btn_inc  = mask[1];
        btn_dec  = mask[2];
        btn_ok   = mask[3];
        repeat (hold) @(negedge CLK);
        {btn_mode, btn_inc, btn_dec, btn_ok} = 4'b0000;
        repeat (3) @(negedge CLK);
    endtask

    task automatic set_cur(input logic [23:0] t);
        {cur_hh, cur_hl, cur_mh, cur_ml, cur_sh, cur_sl} = t;
    endtask

    initial begin
        int exp_hold;
        RST = 1'b1;
        {btn_mode, btn_inc, btn_dec, btn_ok} = 4'b0000;
        set_cur(24'h143705);
        repeat (2) @(negedge CLK);
        check("reset_state", 32'(dut_out), 32'(word(0, 0, 3, 0, 1, 0)));
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        // Enter edit from 14:37:05, then walk the hour through its wrap.
        press(B_MODE, DEB);
        check("enter_edit_h", 32'(dut_out), 32'(word(1, 4, 2, 0, 0, 1)));
        for (int i = 1; i <= 10; i++) begin
            press(B_INC, DEB);
            if (i == 9)  check("hour_inc_to_23", 32'(dut_out), 32'(word(2, 3, 2, 0, 0, 1)));
            if (i == 10) check("hour_23_wraps_00", 32'(dut_out), 32'(word(0, 0, 2, 0, 0, 1)));
        end
        press(B_OK, DEB);
        repeat (2) @(negedge CLK);
        check("idle_after_commit", 32'(dut_out), 32'(word(0, 0, 3, 0, 1, 0)));

        // Minute wrap down, simultaneous inc+dec, then edit to 07:45:30.
        set_cur(24'h120030);
        press(B_MODE, DEB);
        press(B_MODE, DEB);
        check("edit_m_seed_00", 32'(dut_out), 32'(word(0, 0, 1, 0, 0, 1)));
        press(B_DEC, DEB);
        check("min_00_dec_59", 32'(dut_out), 32'(word(5, 9, 1, 0, 0, 1)));
        press(B_INC | B_DEC, DEB);
        check("inc_dec_together", 32'(dut_out), 32'(word(5, 9, 1, 0, 0, 1)));
        for (int i = 0; i < 14; i++) press(B_DEC, DEB);
        check("min_at_45", 32'(dut_out), 32'(word(4, 5, 1, 0, 0, 1)));
        press(B_MODE, DEB);
        check("edit_s_30", 32'(dut_out), 32'(word(3, 0, 0, 0, 0, 1)));
        press(B_MODE, DEB);
        check("mode_wraps_to_h", 32'(dut_out), 32'(word(1, 2, 2, 0, 0, 1)));
        for (int i = 0; i < 5; i++) press(B_DEC, DEB);
        check("hour_at_07", 32'(dut_out), 32'(word(0, 7, 2, 0, 0, 1)));
        btn_ok = 1'b1;
        repeat (DEB) @(negedge CLK);
        btn_ok = 1'b0;
        @(negedge CLK);
        check("load_hour", 32'(dut_out), 32'(word(0, 7, 2, 1, 0, 1)));
        @(negedge CLK);
        check("load_min", 32'(dut_out), 32'(word(4, 5, 1, 1, 0, 1)));
        @(negedge CLK);
        check("load_sec", 32'(dut_out), 32'(word(3, 0, 0, 1, 0, 1)));
        @(negedge CLK);
        check("run_after_load", 32'(dut_out), 32'(word(0, 0, 3, 0, 1, 0)));
        repeat (2) @(negedge CLK);

        // Debounce threshold and single step per press.
        set_cur(24'h102030);
        press(B_MODE, DEB);
        check("edit_h_10", 32'(dut_out), 32'(word(1, 0, 2, 0, 0, 1)));
        press(B_INC, DEB - 1);
        check("short_press_ignored", 32'(dut_out), 32'(word(1, 0, 2, 0, 0, 1)));
        press(B_INC, DEB);
        check("min_press_one_step", 32'(dut_out), 32'(word(1, 1, 2, 0, 0, 1)));
        press(B_INC, DEB + 6);
        check("long_hold_one_step", 32'(dut_out), 32'(word(1, 2, 2, 0, 0, 1)));
        for (int i = 0; i < 3; i++) press(B_DEC, DEB);
        check("hour_10_dec_09", 32'(dut_out), 32'(word(0, 9, 2, 0, 0, 1)));
`ifdef SET_AUTOREPEAT_EN
        exp_hold = 13;
`else
        exp_hold = 10;
`endif
        press(B_INC, DEB + 3 * REP);
        check("held_inc", 32'(dut_out),
              32'(word(4'(exp_hold / 10), 4'(exp_hold % 10), 2, 0, 0, 1)));
        press(B_OK, DEB);
        repeat (3) @(negedge CLK);

        // Out-of-range seeds, then reset in the middle of the load sequence.
        set_cur(24'h31605C);
        press(B_MODE, DEB);
        check("bad_seed_hour", 32'(dut_out), 32'(word(0, 0, 2, 0, 0, 1)));
        press(B_MODE, DEB);
        check("bad_seed_min", 32'(dut_out), 32'(word(0, 0, 1, 0, 0, 1)));
        press(B_MODE, DEB);
        check("bad_seed_sec", 32'(dut_out), 32'(word(0, 0, 0, 0, 0, 1)));
        btn_ok = 1'b1;
        repeat (DEB) @(negedge CLK);
        btn_ok = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check("in_load_m", 32'(dut_out), 32'(word(0, 0, 1, 1, 0, 1)));
        RST = 1'b1;
        @(negedge CLK);
        check("rst_aborts_load", 32'(dut_out), 32'(word(0, 0, 3, 0, 1, 0)));
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("no_load_after_rst", 32'(dut_out), 32'(word(0, 0, 3, 0, 1, 0)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
